md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Multi-cycle multiply/divide unit with HI/LO registers in the E stage, beside the ALU.
//  Takes the forwarded rs/rt operands from the E-stage bypass muxes and decodes ir_e itself.
//  Executes mult/multu/div/divu, mthi/mtlo and supplies mfhi/mflo data into the E-stage result path.
//  Exports start/busy so the hazard unit can stall any md-class instruction held in D.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk     in   1   rising-edge clock
//  reset   in   1   asynchronous, active-low (0 = reset)
//  ir_e    in   32  E-stage instruction word
//  rs_e    in   32  forwarded rs operand (bypass mux output)
//  rt_e    in   32  forwarded rt operand (bypass mux output)
//  start   out  1   comb: ir_e is mult/multu/div/divu and busy==0
//  busy    out  1   registered: operation in progress
//  md_out  out  32  comb: HI if ir_e is mfhi, LO if mflo, else 0
//  hi      out  32  HI register
//  lo      out  32  LO register
// BEHAVIOUR
//  Decode, all with opcode 000000 and funct: mult 011000, multu 011001, div 011010,
//   divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
//  Reset (reset==0, async): hi=0, lo=0, busy=0, cnt=0, pending regs=0; start then depends on ir_e only.
//  State: IDLE (busy=0) / RUN (busy=1). cnt is a down-counter, >=4 bits.
//  IDLE + start at edge: compute result from rs_e/rt_e into pend_hi/pend_lo;
//   cnt <= MULT_CYCLES or DIV_CYCLES; busy <= 1. Operands must be sampled only on this edge.
//  RUN: each edge cnt <= cnt-1. On the edge where cnt==1: hi<=pend_hi, lo<=pend_lo,
//   busy<=0, then IDLE. Net: busy high exactly N cycles after the start cycle, and HI/LO
//   are visible on the first cycle busy==0.
//  mult: {hi,lo} = $signed(rs)*$signed(rt), 64-bit. multu: unsigned 64-bit product.
//  div: lo = quotient truncated toward zero, hi = remainder with dividend's sign.
//   divu: unsigned quotient/remainder.
//  div/divu with rt_e==0: full busy period still runs, hi/lo are left unchanged.
//  div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap for this case.
//  mthi/mtlo in IDLE: hi (resp. lo) <= rs_e at the edge.
//   mthi/mtlo while busy: ignored. The hazard unit must stall these.
//  md-class ir_e while busy: start=0 and the unit ignores it. The hazard unit stalls
//   mult/div/mf*/mt* in D whenever (start|busy).
//  md_out reads the current hi/lo registers combinationally. No internal bypass from a
//   same-edge mthi/mtlo. Any instruction other than mfhi/mflo gives md_out=0.
//  Async reset mid-RUN aborts the operation immediately: pending result discarded, hi/lo=0.
// TESTING
//  Reset release, ir_e=nop -> hi=lo=0, busy=0, start=0, md_out=0.
//  mult, rs=0xFFFFFFFE (-2), rt=3 -> busy high 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//   multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
//  div, rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//   divu 7/0 -> hi/lo unchanged.
//  mthi rs=0x12345678, then mfhi -> md_out=0x12345678.
//   mult issued while busy -> start=0, and the result is unchanged by it.
//  Reset pulsed at cycle 3 of a div -> busy=0, hi=lo=0 immediately.
//   A new mult right after release completes normally.

Source files
------------

// File: rtl/md_unit.sv
// E-stage multiply/divide unit with HI/LO registers: multi-cycle mult/multu/div/divu,
// mthi/mtlo writes and combinational mfhi/mflo read data for the E-stage result mux.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_e,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  output logic        start,
  output logic        busy,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(1);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_pend_hi;
  logic [31:0]   r_pend_lo;
  logic          r_pend_wr;

  logic        w_rtype;
  logic [5:0]  w_funct;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_is_signed;
  logic        w_is_mthi;
  logic        w_is_mtlo;
  logic        w_is_mfhi;
  logic        w_is_mflo;
  logic        w_unused_ir;

  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_prod;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_div_b;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_res_wr;

  // Decode looks only at opcode and funct; the register fields are irrelevant here.
  assign w_rtype     = (ir_e[31:26] == 6'b000000);
  assign w_funct     = ir_e[5:0];
  assign w_unused_ir = ^ir_e[25:6];

  assign w_is_mul    = w_rtype && (w_funct == F_MULT || w_funct == F_MULTU);
  assign w_is_div    = w_rtype && (w_funct == F_DIV  || w_funct == F_DIVU);
  assign w_is_signed = ~w_funct[0];
  assign w_is_mthi   = w_rtype && (w_funct == F_MTHI);
  assign w_is_mtlo   = w_rtype && (w_funct == F_MTLO);
  assign w_is_mfhi   = w_rtype && (w_funct == F_MFHI);
  assign w_is_mflo   = w_rtype && (w_funct == F_MFLO);

  assign busy  = (r_state == S_RUN);
  assign start = (w_is_mul || w_is_div) && !busy;
  assign hi    = r_hi;
  assign lo    = r_lo;

  // Extending by the signedness bit lets one 64-bit multiplier serve mult and multu.
  assign w_mul_a = {{32{w_is_signed & rs_e[31]}}, rs_e};
  assign w_mul_b = {{32{w_is_signed & rt_e[31]}}, rt_e};
  assign w_prod  = w_mul_a * w_mul_b;

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign w_neg_a = w_is_signed & rs_e[31];
  assign w_neg_b = w_is_signed & rt_e[31];
  assign w_mag_a = w_neg_a ? (32'd0 - rs_e) : rs_e;
  assign w_mag_b = w_neg_b ? (32'd0 - rt_e) : rt_e;
  assign w_div_b = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_q_mag = w_mag_a / w_div_b;
  assign w_r_mag = w_mag_a % w_div_b;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_res_hi = w_prod[63:32];
    w_res_lo = w_prod[31:0];
    w_res_wr = 1'b1;
    if (w_is_div) begin
      w_res_lo = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q_mag) : w_q_mag;
      w_res_hi = w_neg_a ? (32'd0 - w_r_mag) : w_r_mag;
      w_res_wr = (rt_e != 32'd0);
    end
  end

  always_comb begin
    md_out = 32'd0;
    if (w_is_mfhi)      md_out = r_hi;
    else if (w_is_mflo) md_out = r_lo;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_pend_wr <= w_res_wr;
            r_cnt     <= w_is_mul ? MULT_LOAD : DIV_LOAD;
            r_state   <= S_RUN;
          end else if (w_is_mthi) begin
            r_hi <= rs_e;
          end else if (w_is_mtlo) begin
            r_lo <= rs_e;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_LAST) begin
            if (r_pend_wr) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO/busy-length records,
// a negedge monitor pops and compares them when busy falls.
module tb_md_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] ir_e;
  logic [31:0] rs_e;
  logic [31:0] rt_e;
  logic        start;
  logic        busy;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .ir_e   (ir_e),
    .rs_e   (rs_e),
    .rt_e   (rt_e),
    .start  (start),
    .busy   (busy),
    .md_out (md_out),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rinst(input logic [5:0] funct);
    return {26'd0, funct};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: measures each busy window and compares HI/LO on the first idle cycle.
  int   mon_len;
  logic mon_prev;
  initial begin
    mon_len  = 0;
    mon_prev = 1'b0;
  end

  always @(negedge clk) begin
    if (!reset) begin
      mon_len  = 0;
      mon_prev = 1'b0;
    end else begin
      if (busy) begin
        mon_len++;
      end else if (mon_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.name, "_hi"}, hi, e.hi);
          check({e.name, "_lo"}, lo, e.lo);
          check({e.name, "_busy_len"}, 32'(mon_len), 32'(e.cycles));
        end
        mon_len = 0;
      end
      mon_prev = busy;
    end
  end

  // Drives one instruction for exactly one clock edge, checking start beforehand.
  task automatic issue(input string name, input logic [31:0] ir, input logic [31:0] rs,
                       input logic [31:0] rt, input logic exp_start);
    @(posedge clk);
    #1;
    ir_e = ir;
    rs_e = rs;
    rt_e = rt;
    #1;
    check({name, "_start"}, 32'(start), 32'(exp_start));
    @(posedge clk);
    #1;
    ir_e = NOP;
    if (exp_start) check({name, "_busy_rise"}, 32'(busy), 32'd1);
  endtask

  task automatic push(input string name, input logic [31:0] h, input logic [31:0] l,
                      input int cyc);
    exp_t e;
    e.name   = name;
    e.hi     = h;
    e.lo     = l;
    e.cycles = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) check({name, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    ir_e  = NOP;
    rs_e  = '0;
    rt_e  = '0;
    repeat (2) @(posedge clk);
    #1;
    ir_e = rinst(6'b011000);
    #1;
    check("reset_start_from_ir", 32'(start), 32'd1);
    ir_e = NOP;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_md_out", md_out, 32'd0);

    push("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    issue("mult", rinst(6'b011000), 32'hFFFF_FFFE, 32'd3, 1'b1);
    wait_idle("mult");

    push("multu", 32'h0000_0002, 32'hFFFF_FFFA, 5);
    issue("multu", rinst(6'b011001), 32'hFFFF_FFFE, 32'd3, 1'b1);
    wait_idle("multu");

    push("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue("div_m7_2", rinst(6'b011010), 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_idle("div_m7_2");

    push("divu_by0", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue("divu_by0", rinst(6'b011011), 32'd7, 32'd0, 1'b1);
    wait_idle("divu_by0");

    push("div_7_m2", 32'h0000_0001, 32'hFFFF_FFFD, 10);
    issue("div_7_m2", rinst(6'b011010), 32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_idle("div_7_m2");

    push("div_ovf", 32'h0000_0000, 32'h8000_0000, 10);
    issue("div_ovf", rinst(6'b011010), 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle("div_ovf");

    push("divu_100_7", 32'h0000_0002, 32'h0000_000E, 10);
    issue("divu_100_7", rinst(6'b011011), 32'd100, 32'd7, 1'b1);
    wait_idle("divu_100_7");

    push("mult_3_4", 32'h0000_0000, 32'h0000_000C, 5);
    issue("mult_3_4", rinst(6'b011000), 32'd3, 32'd4, 1'b1);
    wait_idle("mult_3_4");

    // Divide by zero keeps HI/LO, so an mtlo slipping through while busy would show.
    push("busy_ignore", 32'h0000_0000, 32'h0000_000C, 10);
    issue("busy_ignore", rinst(6'b011011), 32'd5, 32'd0, 1'b1);
    ir_e = rinst(6'b011000);
    rs_e = 32'd100;
    rt_e = 32'd100;
    #1;
    check("mult_while_busy_start", 32'(start), 32'd0);
    @(posedge clk);
    #1;
    ir_e = rinst(6'b010011);
    rs_e = 32'h0000_DEAD;
    @(posedge clk);
    #1;
    ir_e = NOP;
    check("mtlo_while_busy_lo", lo, 32'h0000_000C);
    wait_idle("busy_ignore");

    issue("mthi", rinst(6'b010001), 32'h1234_5678, 32'd0, 1'b0);
    check("mthi_hi", hi, 32'h1234_5678);
    ir_e = rinst(6'b010000);
    #1;
    check("mfhi_md_out", md_out, 32'h1234_5678);
    issue("mtlo", rinst(6'b010011), 32'hCAFE_BABE, 32'd0, 1'b0);
    ir_e = rinst(6'b010010);
    #1;
    check("mflo_md_out", md_out, 32'hCAFE_BABE);
    ir_e = rinst(6'b011000);
    #1;
    check("mult_ir_md_out", md_out, 32'd0);
    ir_e = NOP;

    issue("div_abort", rinst(6'b011010), 32'd100, 32'd3, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    push("mult_after_rst", 32'h0000_0001, 32'h0000_0000, 5);
    issue("mult_after_rst", rinst(6'b011000), 32'h0001_0000, 32'h0001_0000, 1'b1);
    wait_idle("mult_after_rst");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
